// File: rtl/mux_share_pkg.sv
// Shared types and helpers for the mux-share arbiter family.
// Holds the FSM state encoding and a reference round-robin pick function.
package mux_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Generic pick for up to 8 requesters: first set bit at or above ptr, with wrap.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int nreq);
        logic [2:0] w;
        logic       found;
        int         idx;
        w     = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (req[idx] && !found) begin
                    w     = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_share_if.sv
// Request/grant bundle between requesters and the mux-share arbiter.
// MUX_SHARE_LOCK_EN adds a lock input that holds off hold-time preemption.
interface mux_share_if #(
    parameter int NREQ = 4,
    parameter int SELW = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] sel;
    logic            busy;
`ifdef MUX_SHARE_LOCK_EN
    logic            lock;

    modport master (input req, input lock, output gnt, output sel, output busy);
    modport slave  (output req, output lock, input gnt, input sel, input busy);
`else
    modport master (input req, output gnt, output sel, output busy);
    modport slave  (output req, input gnt, input sel, input busy);
`endif
endinterface

// File: rtl/mux_share_arbiter_pick.sv
// rr_priority_pick: combinational round-robin search.
// Rotates req down by ptr, takes the lowest set bit, and rotates the index back.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int SELW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] winner,
    output logic            valid
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SELW-1:0]   idx;
    logic [SELW:0]     sum;
    logic              found;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rot[i] && !found) begin
                idx   = SELW'(i);
                found = 1'b1;
            end
        end
        // Undo the rotation modulo NREQ so non-power-of-two sizes never overflow
        sum = {1'b0, idx} + {1'b0, ptr};
        if (sum >= (SELW+1)'(NREQ)) sum = sum - (SELW+1)'(NREQ);
        winner = sum[SELW-1:0];
        valid  = |req;
    end
endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for a shared N:1 mux: one-hot grant, registered select,
// MAX_HOLD preemption and a dead cycle between owners. Optional: MUX_SHARE_LOCK_EN.
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SELW     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_share_if.master bus
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_HOLD - 1);
    localparam logic [SELW-1:0] LAST    = SELW'(NREQ - 1);

    state_t          state, state_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic [SELW-1:0] sel, sel_n, ptr, ptr_n, winner;
    logic [CW-1:0]   cnt, cnt_n;
    logic            busy, busy_n, win_vld, lock_hold, preempt;

`ifdef MUX_SHARE_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    rr_priority_pick #(.NREQ(NREQ), .SELW(SELW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_vld)
    );

    // Preempt only once the hold budget is spent and someone else is waiting
    assign preempt = (cnt == CNT_MAX) && |(bus.req & ~gnt) && !lock_hold;

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        busy_n  = busy;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            ST_IDLE, ST_RELEASE: begin
                if (win_vld) begin
                    state_n = ST_GRANT;
                    gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    sel_n   = winner;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel] || preempt) begin
                    state_n = ST_RELEASE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = (sel == LAST) ? '0 : sel + 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.gnt  = gnt;
    assign bus.sel  = sel;
    assign bus.busy = busy;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter (NREQ=4, MAX_HOLD=8); a cycle model feeds a scoreboard
// queue, scenario tasks add literal checks. Define MUX_SHARE_LOCK_EN to cover lock.
module tb_mux_share_arbiter;
    localparam int NREQ = 4;
    localparam int MAXH = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_share_if #(.NREQ(4), .SELW(2)) ifc ();

    mux_share_arbiter #(.NREQ(4), .SELW(2), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_state;  // 0 idle, 1 grant, 2 release
    logic [3:0] m_gnt;
    logic [1:0] m_sel;
    logic       m_busy;
    int         m_ptr;
    int         m_cnt;
    exp_t       sbq[$];
    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;

    task automatic model_reset();
        m_state = 0; m_gnt = '0; m_sel = '0; m_busy = 1'b0; m_ptr = 0; m_cnt = 0;
        sbq.delete();
        prev_gnt = '0; prev_sel = '0;
    endtask

    function automatic logic lock_now();
`ifdef MUX_SHARE_LOCK_EN
        return ifc.lock;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic lk);
        int   w;
        logic other;
        w = -1;
        if (m_state != 1) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
                m_state = 1; m_gnt = 4'(1 << w); m_sel = 2'(w); m_busy = 1'b1; m_cnt = 0;
            end else begin
                m_state = 0;
            end
        end else begin
            other = |(r & ~m_gnt);
            if (!r[m_sel] || (m_cnt == MAXH - 1 && other && !lk)) begin
                m_state = 2; m_gnt = '0; m_busy = 1'b0; m_ptr = (int'(m_sel) + 1) % NREQ;
            end else if (m_cnt < MAXH - 1) begin
                m_cnt++;
            end
        end
    endtask

    // One clock: predict, push, advance, then pop and compare away from the edge
    task automatic step();
        exp_t e;
        model_edge(ifc.req, lock_now());
        e.gnt = m_gnt; e.sel = m_sel; e.busy = m_busy;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if ({ifc.gnt, ifc.sel, ifc.busy} !== e) begin
            errors++;
            $display("FAIL model_cmp t=%0t got gnt=%b sel=%0d busy=%b want gnt=%b sel=%0d busy=%b",
                     $time, ifc.gnt, ifc.sel, ifc.busy, e.gnt, e.sel, e.busy);
        end
        checks++;
        if (!$onehot0(ifc.gnt)) begin
            errors++;
            $display("FAIL onehot t=%0t got gnt=%b want zero-or-onehot", $time, ifc.gnt);
        end
        checks++;
        if (ifc.sel !== prev_sel && !(prev_gnt == 4'b0 && ifc.gnt != 4'b0)) begin
            errors++;
            $display("FAIL sel_stable t=%0t got sel=%0d want %0d", $time, ifc.sel, prev_sel);
        end
        prev_gnt = ifc.gnt;
        prev_sel = ifc.sel;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifc.gnt !== 4'b0 || ifc.sel !== 2'd0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL in_reset got gnt=%b sel=%0d busy=%b want 0000/0/0",
                     ifc.gnt, ifc.sel, ifc.busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ifc.req = 4'b1111;
        do_reset();
        step();
        checks++;
        if (ifc.gnt !== 4'b0001 || ifc.sel !== 2'd0 || ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant got gnt=%b sel=%0d busy=%b want 0001/0/1",
                     ifc.gnt, ifc.sel, ifc.busy);
        end
    endtask

    task automatic test_single();
        logic [3:0] want [5];
        want = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        ifc.req = 4'b0;
        do_reset();
        ifc.req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) ifc.req = 4'b0;
            step();
            checks++;
            if (ifc.gnt !== want[i] || ifc.sel !== 2'd2) begin
                errors++;
                $display("FAIL single[%0d] got gnt=%b sel=%0d want gnt=%b sel=2",
                         i, ifc.gnt, ifc.sel, want[i]);
            end
        end
    endtask

    task automatic test_max_hold();
        logic [3:0] w;
        int p;
        ifc.req = 4'b0;
        do_reset();
        ifc.req = 4'b0011;
        for (int i = 0; i < 36; i++) begin
            step();
            p = i % 18;
            w = (p < 8) ? 4'b0001 : (p == 8 || p == 17) ? 4'b0000 : 4'b0010;
            checks++;
            if (ifc.gnt !== w) begin
                errors++;
                $display("FAIL max_hold[%0d] got gnt=%b want %b", i, ifc.gnt, w);
            end
        end
    endtask

    task automatic test_saturate();
        ifc.req = 4'b0;
        do_reset();
        ifc.req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (ifc.gnt !== 4'b1000) begin
                errors++;
                $display("FAIL saturate[%0d] got gnt=%b want 1000", i, ifc.gnt);
            end
        end
        checks++;
        if (dut.cnt !== 3'd7) begin
            errors++;
            $display("FAIL cnt_sat got %0d want 7", dut.cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] order [5];
        logic [1:0] seen  [$];
        logic [3:0] last;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ifc.req = 4'b0;
        do_reset();
        ifc.req = 4'b1111;
        last = 4'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last == 4'b0 && ifc.gnt != 4'b0) seen.push_back(ifc.sel);
            last = ifc.gnt;
        end
        checks++;
        if (seen.size() < 5) begin
            errors++;
            $display("FAIL wrap_count got %0d grants want >=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] !== order[i]) begin
                    errors++;
                    $display("FAIL wrap_order[%0d] got %0d want %0d", i, seen[i], order[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ifc.req = 4'b0;
        do_reset();
        ifc.req = 4'b1000;
        step();
        ifc.req = 4'b1010;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (ifc.gnt !== 4'b0 || ifc.sel !== 2'd0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got gnt=%b sel=%0d busy=%b want 0000/0/0",
                     ifc.gnt, ifc.sel, ifc.busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (ifc.gnt !== 4'b0010 || ifc.sel !== 2'd1) begin
            errors++;
            $display("FAIL post_reset got gnt=%b sel=%0d want 0010/1", ifc.gnt, ifc.sel);
        end
    endtask

    task automatic test_random();
        ifc.req = 4'b0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) ifc.req = 4'($urandom_range(0, 15));
`ifdef MUX_SHARE_LOCK_EN
            if (i % 7 == 0) ifc.lock = 1'($urandom_range(0, 1));
`endif
            step();
        end
`ifdef MUX_SHARE_LOCK_EN
        ifc.lock = 1'b0;
`endif
    endtask

`ifdef MUX_SHARE_LOCK_EN
    task automatic test_lock();
        ifc.req  = 4'b0;
        ifc.lock = 1'b0;
        do_reset();
        ifc.req  = 4'b0011;
        ifc.lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (ifc.gnt !== 4'b0001) begin
                errors++;
                $display("FAIL lock_hold[%0d] got gnt=%b want 0001", i, ifc.gnt);
            end
        end
        ifc.req  = 4'b0010;
        ifc.lock = 1'b0;
        step();
        checks++;
        if (ifc.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL lock_release got gnt=%b want 0000", ifc.gnt);
        end
        step();
        checks++;
        if (ifc.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_next got gnt=%b want 0010", ifc.gnt);
        end
    endtask
`endif

    initial begin
        ifc.req = 4'b0;
`ifdef MUX_SHARE_LOCK_EN
        ifc.lock = 1'b0;
`endif
        model_reset();
        test_reset();
        test_single();
        test_max_hold();
        test_saturate();
        test_wrap();
        test_reset_mid();
`ifdef MUX_SHARE_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
